scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
- Sequences one scan chain built from SDFFRX1-type cells through repeated load / capture / unload cycles for a programmed number of patterns.
- Pulls stimulus bits from a pattern source and pushes captured response bits to a response sink, using valid/ready handshakes on both sides.
- Drives the chain's SE and SI pins and a clock-enable for the chain's external clock gate, so the chain advances only when both handshakes allow.

Parameters:
- CHAIN_LEN, 8, number of flops in the chain (>=2).
- PAT_W, 8, width of the pattern-count input and counter.

Ports:
- CK  in  1  clock.
- RN  in  1  asynchronous active-low reset.
- start  in  1  begin a test run; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE.
- num_pat  in  PAT_W  number of patterns; sampled with start.
- pat_valid  in  1  stimulus bit available.
- pat_bit  in  1  stimulus bit.
- pat_ready  out  1  stimulus bit consumed this cycle.
- scan_out  in  1  Q of the chain tail flop.
- resp_valid  out  1  response bit offered.
- resp_bit  out  1  response bit (equals scan_out).
- resp_ready  in  1  sink accepts the response bit.
- se  out  1  scan enable to the chain.
- si  out  1  scan input to the chain head.
- chain_ck_en  out  1  chain clock-gate enable; the chain clocks on an edge only if this is 1 in the preceding cycle.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pat_idx  out  PAT_W  index of the pattern currently being loaded.

Behaviour:
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- Registers: state, bit_cnt (0..CHAIN_LEN-1), pat_left, first flag, pat_idx.
- Reset (RN=0, asynchronous): state=IDLE and all counters 0. All outputs are then 0: se, si, pat_ready, resp_valid, resp_bit-qualified, chain_ck_en, busy, done, pat_idx.
- IDLE, start=1:
  - num_pat=0 -> DONE.
  - Otherwise -> SHIFT, with pat_left=num_pat, first=1, pat_idx=0, bit_cnt=0.
- busy=1 in SHIFT, CAPTURE and UNLOAD. start is ignored while not in IDLE.
- SHIFT:
  - se=1.
  - beat = pat_valid && (first || resp_ready).
  - On beat: chain_ck_en=1, pat_ready=1, si=pat_bit, bit_cnt++.
  - resp_valid = pat_valid && !first. No response is offered while the first pattern loads, because chain contents are don't-care.
  - No beat: chain_ck_en=0, pat_ready=0, counters hold.
  - Beat with bit_cnt==CHAIN_LEN-1 -> CAPTURE, bit_cnt=0.
- CAPTURE: exactly one cycle with se=0, chain_ck_en=1, si=0, no handshakes. Then pat_left--, first=0, and:
  - pat_left was 1 -> UNLOAD.
  - Otherwise -> SHIFT with pat_idx++.
- UNLOAD:
  - se=1, si=0, resp_valid=1.
  - beat = resp_ready; chain_ck_en=beat.
  - After CHAIN_LEN beats -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Response order: tail flop first, i.e. the bit captured by the flop nearest scan_out leaves first.
- Combinational outputs: si, pat_ready, resp_valid, resp_bit and chain_ck_en are combinational from state, pat_valid, pat_bit, resp_ready and scan_out. se, busy, done and pat_idx decode registered state only.
- abort=1 in any state except IDLE: chain_ck_en=0 and no handshake that cycle; next state IDLE, no done pulse. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- RN asserted mid-operation: outputs drop to 0 immediately; the partially shifted chain is abandoned.

Decomposition:
- Package scan_ctrl_pkg holds:
  - the state enum {IDLE, SHIFT, CAPTURE, UNLOAD, DONE};
  - the function clog2-based bit-counter width derived from CHAIN_LEN.
- One natural sub-module: scan_bit_counter. It is a CHAIN_LEN-modulo counter with increment-enable, synchronous clear, asynchronous RN clear and a terminal-count flag. The same instance is used in SHIFT and UNLOAD.

Test Plan:
Common bench: CHAIN_LEN=4, a chain of 4 SDFFRX1 with functional D tied to {d3,d2,d1,d0}=0110, and the d3 flop driving scan_out. pat_valid=resp_ready=1 unless stated.
- num_pat=1, stimulus 1,0,1,1 -> 4 SHIFT beats with resp_valid=0; 1 CAPTURE cycle with se=0; 4 UNLOAD beats with resp bits 0,1,1,0; done pulses 10 cycles after start is sampled; busy then falls.
- num_pat=2, stimulus A=1111, B=0000 -> the second SHIFT streams resp 0,1,1,0 while loading B; UNLOAD returns 0,1,1,0 again; pat_idx goes 0 then 1; exactly 2 cycles with se=0.
- Pattern stall: pat_valid=0 for 3 cycles mid-SHIFT at bit_cnt=2 -> chain_ck_en=0 and pat_ready=0 for those 3 cycles, chain Q unchanged, run completes correctly 3 cycles late.
- Sink stall: resp_ready=0 for 2 cycles in UNLOAD -> chain_ck_en=0, resp_bit held stable and resp_valid=1 throughout; no bit lost or duplicated.
- num_pat=0 -> done=1 on the cycle after start; chain_ck_en and se stay 0 for the whole run.
- RN pulled low during SHIFT at bit_cnt=1 -> all outputs 0 immediately. Separately, abort=1 in CAPTURE -> IDLE next cycle with no done pulse; a fresh start afterwards runs normally.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types for the scan chain controller.
// State encoding and bit-counter width helper.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    UNLOAD,
    DONE
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_bit_counter.sv
// Modulo-N bit counter with terminal-count flag.
// Shared between chain load and chain unload.
module scan_bit_counter
  import scan_ctrl_pkg::*;
#(
  parameter int N = 8,
  parameter int W = cnt_w(N)
) (
  input  logic CK,
  input  logic RN,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load / capture / unload sequencer for one scan chain.
// Chain advances only on cycles where both handshakes allow.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int PAT_W     = 8
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] num_pat,
  input  logic             pat_valid,
  input  logic             pat_bit,
  output logic             pat_ready,
  input  logic             scan_out,
  output logic             resp_valid,
  output logic             resp_bit,
  input  logic             resp_ready,
  output logic             se,
  output logic             si,
  output logic             chain_ck_en,
  output logic             busy,
  output logic             done,
  output logic [PAT_W-1:0] pat_idx
);

  state_t           state;
  state_t           state_nx;
  logic [PAT_W-1:0] pat_left;
  logic [PAT_W-1:0] pat_left_nx;
  logic [PAT_W-1:0] idx_nx;
  logic             first;
  logic             first_nx;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             cnt_tc;

  scan_bit_counter #(
    .N (CHAIN_LEN)
  ) u_cnt (
    .CK  (CK),
    .RN  (RN),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  assign cnt_clr  = (state == IDLE) || abort;
  assign se       = (state == SHIFT) || (state == UNLOAD);
  assign busy     = se || (state == CAPTURE);
  assign done     = (state == DONE);
  assign resp_bit = resp_valid & scan_out;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      pat_left <= '0;
      first    <= 1'b0;
      pat_idx  <= '0;
    end else begin
      state    <= state_nx;
      pat_left <= pat_left_nx;
      first    <= first_nx;
      pat_idx  <= idx_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pat_left_nx = pat_left;
    first_nx    = first;
    idx_nx      = pat_idx;
    pat_ready   = 1'b0;
    si          = 1'b0;
    resp_valid  = 1'b0;
    chain_ck_en = 1'b0;
    cnt_inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_pat == '0) begin
            state_nx = DONE;
          end else begin
            state_nx    = SHIFT;
            pat_left_nx = num_pat;
            first_nx    = 1'b1;
            idx_nx      = '0;
          end
        end
      end
      SHIFT: begin
        // first load streams out don't-care chain contents
        resp_valid = pat_valid && !first && !abort;
        if (pat_valid && (first || resp_ready) && !abort) begin
          pat_ready   = 1'b1;
          si          = pat_bit;
          chain_ck_en = 1'b1;
          cnt_inc     = 1'b1;
          if (cnt_tc) state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!abort) begin
          chain_ck_en = 1'b1;
          pat_left_nx = pat_left - PAT_W'(1);
          first_nx    = 1'b0;
          if (pat_left == PAT_W'(1)) begin
            state_nx = UNLOAD;
          end else begin
            state_nx = SHIFT;
            idx_nx   = pat_idx + PAT_W'(1);
          end
        end
      end
      UNLOAD: begin
        resp_valid = !abort;
        if (resp_ready && !abort) begin
          chain_ck_en = 1'b1;
          cnt_inc     = 1'b1;
          if (cnt_tc) state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) state_nx = IDLE;
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl driving a 4-flop scan chain model.
// Directed scenarios followed by randomized runs.
module tb_scan_chain_ctrl;

  localparam int L = 4;
  localparam int PW = 8;
  localparam logic [3:0] DFUNC = 4'b0110;

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] num_pat = '0;
  logic          pat_valid = 1'b1;
  logic          pat_bit = 1'b0;
  logic          pat_ready;
  logic          scan_out;
  logic          resp_valid;
  logic          resp_bit;
  logic          resp_ready = 1'b1;
  logic          se;
  logic          si;
  logic          chain_ck_en;
  logic          busy;
  logic          done;
  logic [PW-1:0] pat_idx;

  scan_chain_ctrl #(
    .CHAIN_LEN (L),
    .PAT_W     (PW)
  ) dut (
    .CK          (CK),
    .RN          (RN),
    .start       (start),
    .abort       (abort),
    .num_pat     (num_pat),
    .pat_valid   (pat_valid),
    .pat_bit     (pat_bit),
    .pat_ready   (pat_ready),
    .scan_out    (scan_out),
    .resp_valid  (resp_valid),
    .resp_bit    (resp_bit),
    .resp_ready  (resp_ready),
    .se          (se),
    .si          (si),
    .chain_ck_en (chain_ck_en),
    .busy        (busy),
    .done        (done),
    .pat_idx     (pat_idx)
  );

  always #5 CK = ~CK;

  // q[0] is the head flop, q[3] drives scan_out
  logic [3:0] q;
  always @(posedge CK or negedge RN) begin
    if (!RN) q <= '0;
    else if (chain_ck_en) q <= se ? {q[2:0], si} : DFUNC;
  end
  assign scan_out = q[3];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  bit m_run = 0;
  bit m_done = 0;
  int m_npat = 0;
  int m_pat = 0;
  int m_bits = 0;
  int m_unl = 0;
  int m_idx = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int se0_cnt = 0;
  bit exp_resp[$];
  bit loaded[$];
  bit resp_log[$];
  int idx_log[$];

  always @(negedge CK) begin : model
    bit in_sh, in_cp, in_un, fst, idle_now;
    bit e_pr, e_rv, e_ck, e_si, e_rb;
    logic [3:0] want;
    cyc++;
    if (!RN) begin
      chk("rst_outs", {se, si, pat_ready, resp_valid, resp_bit,
                       chain_ck_en, busy, done, pat_idx}, 0);
      m_run = 0;
      m_done = 0;
      m_idx = 0;
      exp_resp.delete();
      loaded.delete();
    end else begin
      idle_now = !m_run && !m_done;
      in_cp = m_run && (m_bits == L);
      in_un = m_run && (m_pat == m_npat);
      in_sh = m_run && !in_cp && !in_un;
      fst = (m_pat == 0);
      e_pr = in_sh && pat_valid && (fst || resp_ready) && !abort;
      e_rv = !abort && ((in_sh && pat_valid && !fst) || in_un);
      e_ck = e_pr || (in_cp && !abort) || (in_un && resp_ready && !abort);
      e_si = e_pr && pat_bit;
      e_rb = e_rv && q[3];
      chk("se", se, in_sh || in_un);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("pat_idx", pat_idx, m_idx);
      chk("pat_ready", pat_ready, e_pr);
      chk("resp_valid", resp_valid, e_rv);
      chk("chain_ck_en", chain_ck_en, e_ck);
      chk("si", si, e_si);
      chk("resp_bit", resp_bit, e_rb);
      if (e_rv && resp_ready) begin
        resp_log.push_back(resp_bit);
        chk("resp_avail", exp_resp.size() > 0, 1);
        if (exp_resp.size() > 0) chk("resp_data", resp_bit, exp_resp.pop_front());
      end
      if (in_cp) begin
        chk("load_len", loaded.size(), L);
        if (loaded.size() == L) begin
          want = {loaded[0], loaded[1], loaded[2], loaded[3]};
          chk("load_bits", q, want);
        end
        if (!abort) begin
          for (int i = 3; i >= 0; i--) exp_resp.push_back(DFUNC[i]);
        end
        loaded.delete();
      end
      if (e_pr) loaded.push_back(pat_bit);
      if (m_run && !(in_sh || in_un)) se0_cnt++;
      if (m_done) begin
        done_cyc = cyc;
        done_cnt++;
        chk("resp_drain", exp_resp.size(), 0);
      end
      if (m_run && (idx_log.size() == 0 || idx_log[$] != m_idx))
        idx_log.push_back(m_idx);
      m_done = 0;
      if (idle_now) begin
        if (start) begin
          start_cyc = cyc;
          resp_log.delete();
          idx_log.delete();
          exp_resp.delete();
          loaded.delete();
          se0_cnt = 0;
          if (num_pat == 0) begin
            m_done = 1;
          end else begin
            m_run = 1;
            m_npat = num_pat;
            m_pat = 0;
            m_bits = 0;
            m_unl = 0;
            m_idx = 0;
          end
        end
      end else if (m_run && abort) begin
        m_run = 0;
        exp_resp.delete();
        loaded.delete();
      end else if (e_pr) begin
        m_bits++;
      end else if (in_cp) begin
        m_bits = 0;
        m_pat++;
        if (m_pat < m_npat) m_idx = m_pat;
      end else if (in_un && resp_ready) begin
        m_unl++;
        if (m_unl == L) begin
          m_run = 0;
          m_done = 1;
        end
      end
    end
  end

  bit stim[$];

  // one clock cycle; entered and left at posedge+1
  task automatic step();
    pat_bit = (stim.size() > 0) ? stim[0] : 1'($urandom);
    @(negedge CK);
    if (pat_ready && stim.size() > 0) stim.delete(0);
    @(posedge CK);
    #1;
  endtask

  task automatic start_run(input int n);
    num_pat = PW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int k = 0;
    while ((m_run || m_done) && k < budget) begin
      if (rnd) begin
        pat_valid = ($urandom_range(0, 3) != 0);
        resp_ready = ($urandom_range(0, 3) != 0);
        abort = ($urandom_range(0, 59) == 0);
        start = ($urandom_range(0, 19) == 0);
        num_pat = PW'($urandom_range(0, 3));
        if ($urandom_range(0, 199) == 0) RN = 1'b0;
      end
      step();
      RN = 1'b1;
      k++;
    end
    pat_valid = 1'b1;
    resp_ready = 1'b1;
    abort = 1'b0;
    start = 1'b0;
    chk("run_in_budget", k < budget, 1);
  endtask

  function automatic int packed_resp();
    int v = 0;
    foreach (resp_log[i]) v = (v << 1) | int'(resp_log[i]);
    return v;
  endfunction

  task automatic load_stim(input logic [31:0] bits, input int n);
    stim.delete();
    for (int i = n - 1; i >= 0; i--) stim.push_back(bits[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [3:0] qsave;
    RN = 1'b0;
    #1;
    chk("reset_outs", {se, si, pat_ready, resp_valid, resp_bit,
                       chain_ck_en, busy, done, pat_idx}, 0);
    repeat (2) step();
    RN = 1'b1;
    step();

    // single pattern, stimulus 1,0,1,1
    load_stim(32'b1011, 4);
    start_run(1);
    wait_idle(60, 0);
    chk("t1_latency", done_cyc - start_cyc, 10);
    chk("t1_resp", packed_resp(), 32'b0110);
    chk("t1_nresp", resp_log.size(), 4);
    chk("t1_capture", se0_cnt, 1);

    // two patterns: second load streams the first capture
    load_stim(32'b1111_0000, 8);
    start_run(2);
    wait_idle(60, 0);
    chk("t2_latency", done_cyc - start_cyc, 15);
    chk("t2_resp", packed_resp(), 32'b0110_0110);
    chk("t2_capture", se0_cnt, 2);
    chk("t2_idx_n", idx_log.size(), 2);
    if (idx_log.size() == 2) begin
      chk("t2_idx0", idx_log[0], 0);
      chk("t2_idx1", idx_log[1], 1);
    end

    // source stall at bit_cnt=2
    load_stim(32'b1011, 4);
    start_run(1);
    step();
    step();
    pat_valid = 1'b0;
    qsave = q;
    repeat (3) begin
      #2;
      chk("t3_ck_en", chain_ck_en, 0);
      chk("t3_pat_ready", pat_ready, 0);
      step();
    end
    chk("t3_chain_held", q, qsave);
    pat_valid = 1'b1;
    wait_idle(60, 0);
    chk("t3_latency", done_cyc - start_cyc, 13);
    chk("t3_resp", packed_resp(), 32'b0110);

    // sink stall during unload
    load_stim(32'b0101, 4);
    start_run(1);
    repeat (6) step();
    resp_ready = 1'b0;
    repeat (2) begin
      #2;
      chk("t4_ck_en", chain_ck_en, 0);
      chk("t4_valid", resp_valid, 1);
      chk("t4_bit", resp_bit, 1);
      step();
    end
    resp_ready = 1'b1;
    wait_idle(60, 0);
    chk("t4_latency", done_cyc - start_cyc, 12);
    chk("t4_resp", packed_resp(), 32'b0110);
    chk("t4_nresp", resp_log.size(), 4);

    // zero patterns
    start_run(0);
    wait_idle(10, 0);
    chk("t5_latency", done_cyc - start_cyc, 1);

    // reset mid-shift at bit_cnt=1
    load_stim(32'b1100, 4);
    start_run(1);
    step();
    RN = 1'b0;
    #1;
    chk("t6_rst_outs", {se, si, pat_ready, resp_valid, resp_bit,
                        chain_ck_en, busy, done, pat_idx}, 0);
    step();
    RN = 1'b1;
    step();

    // abort during capture, then a clean run
    load_stim(32'b1010_0101, 8);
    start_run(2);
    repeat (4) step();
    #2;
    chk("t7_in_capture", {se, busy}, 2'b01);
    d0 = done_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t7_idle", busy, 0);
    repeat (2) step();
    chk("t7_no_done", done_cnt, d0);
    load_stim(32'b1011, 4);
    start_run(1);
    wait_idle(60, 0);
    chk("t7_latency", done_cyc - start_cyc, 10);
    chk("t7_resp", packed_resp(), 32'b0110);

    // start and abort together in IDLE: start wins
    load_stim(32'b0011, 4);
    num_pat = PW'(1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("t8_busy", busy, 1);
    wait_idle(60, 0);
    chk("t8_latency", done_cyc - start_cyc, 10);

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      stim.delete();
      abort = ($urandom_range(0, 3) == 0);
      start_run($urandom_range(0, 3));
      abort = 1'b0;
      wait_idle(400, 1);
      repeat (2) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
